muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that runs the iterative add/subtract steps on the shared 32-bit ALU instead of dedicated multiply/divide hardware. It sits beside the EX stage, borrows the ALU through a request/grant pair, and keeps the HI/LO result registers. The pipeline stalls on `busy` and reads `hi`/`lo` after `done`.

## Interface
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: launch an operation; sampled only in IDLE.
- `op` in 2: operation select.
  - 00 MULT
  - 01 MULTU
  - 10 DIV
  - 11 DIVU
- `src_a` in 32: multiplicand or dividend.
- `src_b` in 32: multiplier or divisor.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid in that cycle.
- `dz` out 1: divide-by-zero flag; pulses together with `done`.
- `hi` out 32: HI register (product high word, or remainder).
- `lo` out 32: LO register (product low word, or quotient).
- `alu_req` out 1: ALU wanted this cycle; high throughout ITER.
- `alu_gnt` in 1: ALU granted to this block this cycle.
- `alu_a`, `alu_b` out 32 each: ALU operands.
- `alu_control` out 4: ALU function select.
  - 4'b0110 ADDU
  - 4'b1011 SUBU
- `alu_q` in 32: ALU result, combinational within the same cycle.
- `alu_cf` in 1: ALU carry-out. For SUBU, 1 means no borrow (a ≥ b unsigned).

## Operation
- **States:** IDLE → PREP → ITER → FIX → DONE → IDLE.
- **IDLE:** on `start`, latch `op` and the operands, go to PREP. Otherwise hold `hi`/`lo`.
- **PREP (1 cycle):**
  - For signed ops, record `sa = src_a[31]` and `sb = src_b[31]`, then replace each operand with its magnitude (local two's complement). Unsigned ops use `sa = sb = 0`.
  - Clear the iteration counter.
  - On a divide with divisor 0: go directly to DONE with `hi = src_a`, `lo = 32'hFFFF_FFFF`, `dz = 1`.
- **ITER:** 32 steps. A step executes only in a cycle where `alu_gnt = 1`; in any other cycle all registers hold.
- **Multiply step:**
  - Registers: `{hi, lo}`, with `hi = 0` and `lo = |b|` at entry.
  - ALU inputs: `alu_a = hi`, `alu_b = |a|`, ADDU.
  - If `lo[0]`: `{hi, lo} <= {alu_cf, alu_q, lo[31:1]}`.
  - Else: `{hi, lo} <= {1'b0, hi, lo[31:1]}`.
- **Divide step (restoring):**
  - Registers: `R = hi` (starts at 0) and `Q = lo` (starts at `|a|`).
  - Let `r_msb = R[31]` and `R' = {R[30:0], Q[31]}`.
  - ALU inputs: `alu_a = R'`, `alu_b = |b|`, SUBU.
  - If `r_msb | alu_cf`: `R <= alu_q`, `Q <= {Q[30:0], 1}`.
  - Else: `R <= R'`, `Q <= {Q[30:0], 0}`.
- **FIX (1 cycle), sign correction:**
  - MULT: if `sa ^ sb`, negate the 64-bit `{hi, lo}`.
  - DIV: negate `lo` if `sa ^ sb`; negate `hi` if `sa`.
- **DONE (1 cycle):** `done = 1`, then return to IDLE.
- **Arithmetic rules:**
  - All values are modulo 2^32 per word.
  - DIV of 0x8000_0000 by −1 gives `lo = 0x8000_0000`, `hi = 0`.
- **Boundary conditions:**
  - `start` while busy is ignored.
  - `alu_gnt` has no effect outside ITER.
  - Reset in any state aborts immediately to IDLE; the result is lost.

## Timing
- **Reset values:** all outputs 0 (`busy`, `done`, `dz`, `hi`, `lo`, `alu_req`, `alu_a`, `alu_b`, `alu_control`); state IDLE.
- **Latency:** `start` sampled at edge 0. PREP is cycle 1, ITER is cycles 2–33 (with continuous grant), FIX is cycle 34, DONE is cycle 35.
  - `done` goes high 35 cycles after the start edge.
  - Every cycle without a grant during ITER adds one cycle.
- **Divide-by-zero:** `done` and `dz` high in cycle 2.
- **`busy`:** high from cycle 1 through the DONE cycle.
- **Back-to-back:** a new `start` is accepted in the cycle right after DONE.
- **ALU outputs outside ITER:** `alu_a = alu_b = 0` and `alu_control = 0`; `alu_req` low.

## Configuration
- **`MULDIV_DIV_EN` defined:** full behaviour as specified above.
- **`MULDIV_DIV_EN` undefined:**
  - The divide datapath is removed.
  - DIV/DIVU go IDLE → DONE with `hi`/`lo` unchanged and `dz = 1`.
  - MULT/MULTU are unaffected.

## Structure
- **Shared package/header:**
  - op encodings
  - ALU codes `ALU_ADDU = 4'b0110`, `ALU_SUBU = 4'b1011`
  - state encoding
  - iteration count 32
- **Sub-module `neg_cond64`:** conditional two's complement of 64 bits, plus a 32-bit mode. Used by PREP and FIX.

## Test plan
- MULT 7 × −3 → `hi = FFFFFFFF`, `lo = FFFFFFEB`; `done` at cycle 35.
- MULTU FFFFFFFF × FFFFFFFF → `hi = FFFFFFFE`, `lo = 00000001`.
- DIV −7 / 2 → `lo = FFFFFFFD`, `hi = FFFFFFFF`.
- DIVU 100 / 7 → `lo = 0000000E`, `hi = 00000002`.
- DIVU 5 / 0 → `done` and `dz` in cycle 2; `hi = 5`, `lo = FFFFFFFF`.
- MULTU 3 × 5 with `alu_gnt` low on alternate cycles → result 15; `done` delayed by exactly the number of denied cycles.
- Extra `start` pulses mid-op → ignored.
- `rst_n` low at ITER step 10 → all outputs 0; the next op runs correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the muldiv_seq sequencer: operation codes, ALU function
// codes, FSM states and the iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  localparam logic [3:0] ALU_ADDU = 4'b0110;
  localparam logic [3:0] ALU_SUBU = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int unsigned ITER_COUNT = 32;

  // Ops with a 0 in bit 0 (MULT, DIV) are signed.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq_neg_cond64.sv
// Conditional two's complement: one 64-bit negation (neg_lo selects), or in
// mode32 two independent 32-bit negations of the upper and lower words.
module neg_cond64 (
  input  logic [63:0] din,
  input  logic        neg_hi,
  input  logic        neg_lo,
  input  logic        mode32,
  output logic [63:0] dout
);

  logic [63:0] full_n_s;
  logic [31:0] hi_n_s;
  logic [31:0] lo_n_s;

  assign full_n_s = ~din + 64'd1;
  assign hi_n_s   = ~din[63:32] + 32'd1;
  assign lo_n_s   = ~din[31:0] + 32'd1;

  // Select per-word or whole-word negation
  always_comb begin
    dout = din;
    if (mode32) begin
      dout = {(neg_hi ? hi_n_s : din[63:32]), (neg_lo ? lo_n_s : din[31:0])};
    end else begin
      dout = neg_lo ? full_n_s : din;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer using the shared ALU via req/gnt.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_q,
  input  logic        alu_cf
);

  state_e      state_r;
  logic [1:0]  op_r;
  logic [31:0] op_a_r, op_b_r, hi_r, lo_r;
  logic        sa_r, sb_r, busy_r, done_r, dz_r;
  logic [5:0]  cnt_r;

  logic        div_s;
  logic [63:0] neg_din_s, neg_dout_s;
  logic        neg_hi_s, neg_lo_s, mode32_s;
  logic [31:0] hi_mul_s, lo_mul_s;

  assign div_s = op_r[1];
  assign busy  = busy_r;
  assign done  = done_r;
  assign dz    = dz_r;
  assign hi    = hi_r;
  assign lo    = lo_r;

  neg_cond64 u_neg (
    .din    (neg_din_s),
    .neg_hi (neg_hi_s),
    .neg_lo (neg_lo_s),
    .mode32 (mode32_s),
    .dout   (neg_dout_s)
  );

  // Negator input: operand magnitudes in PREP, sign fix-up of the result in FIX
  always_comb begin
    neg_din_s = {op_a_r, op_b_r};
    neg_hi_s  = op_is_signed(op_r) & op_a_r[31];
    neg_lo_s  = op_is_signed(op_r) & op_b_r[31];
    mode32_s  = 1'b1;
    if (state_r == ST_FIX) begin
      neg_din_s = {hi_r, lo_r};
      neg_hi_s  = div_s & sa_r;
      neg_lo_s  = sa_r ^ sb_r;
      mode32_s  = div_s;
    end else begin
      neg_din_s = {op_a_r, op_b_r};
    end
  end

  // Shift-add multiply step; carry-out becomes the new top bit
  always_comb begin
    hi_mul_s = {1'b0, hi_r[31:1]};
    lo_mul_s = {hi_r[0], lo_r[31:1]};
    if (lo_r[0]) begin
      hi_mul_s = {alu_cf, alu_q[31:1]};
      lo_mul_s = {alu_q[0], lo_r[31:1]};
    end else begin
      hi_mul_s = {1'b0, hi_r[31:1]};
    end
  end

`ifdef MULDIV_DIV_EN
  logic [31:0] r_shift_s, hi_div_s, lo_div_s;
  logic        take_s;

  assign r_shift_s = {hi_r[30:0], lo_r[31]};

  // Restoring divide step; a set R[31] means the shifted remainder exceeds any divisor
  always_comb begin
    take_s   = hi_r[31] | alu_cf;
    hi_div_s = r_shift_s;
    if (take_s) begin
      hi_div_s = alu_q;
    end else begin
      hi_div_s = r_shift_s;
    end
    lo_div_s = {lo_r[30:0], take_s};
  end
`endif

  // ALU operand drive, only while iterating
  always_comb begin
    alu_req     = 1'b0;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    alu_control = 4'd0;
    if (state_r == ST_ITER) begin
      alu_req = 1'b1;
      alu_b   = op_b_r;
`ifdef MULDIV_DIV_EN
      if (div_s) begin
        alu_a       = r_shift_s;
        alu_control = ALU_SUBU;
      end else begin
        alu_a       = hi_r;
        alu_control = ALU_ADDU;
      end
`else
      alu_a       = hi_r;
      alu_control = ALU_ADDU;
`endif
    end else begin
      alu_req = 1'b0;
    end
  end

  // Sequencer FSM with registered status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= 2'd0;
      op_a_r  <= 32'd0;
      op_b_r  <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      cnt_r   <= 6'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          dz_r   <= 1'b0;
          if (start) begin
            op_r   <= op;
            op_a_r <= src_a;
            op_b_r <= src_b;
            busy_r <= 1'b1;
`ifdef MULDIV_DIV_EN
            state_r <= ST_PREP;
`else
            if (op[1]) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              dz_r    <= 1'b1;
            end else begin
              state_r <= ST_PREP;
            end
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_PREP: begin
          sa_r  <= neg_hi_s;
          sb_r  <= neg_lo_s;
          cnt_r <= 6'd0;
`ifdef MULDIV_DIV_EN
          if (div_s && (op_b_r == 32'd0)) begin
            hi_r    <= op_a_r;
            lo_r    <= 32'hFFFF_FFFF;
            dz_r    <= 1'b1;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (div_s) begin
            hi_r    <= 32'd0;
            lo_r    <= neg_dout_s[63:32];
            op_b_r  <= neg_dout_s[31:0];
            state_r <= ST_ITER;
          end else begin
            hi_r    <= 32'd0;
            lo_r    <= neg_dout_s[31:0];
            op_b_r  <= neg_dout_s[63:32];
            state_r <= ST_ITER;
          end
`else
          hi_r    <= 32'd0;
          lo_r    <= neg_dout_s[31:0];
          op_b_r  <= neg_dout_s[63:32];
          state_r <= ST_ITER;
`endif
        end
        ST_ITER: begin
          if (alu_gnt) begin
`ifdef MULDIV_DIV_EN
            hi_r <= div_s ? hi_div_s : hi_mul_s;
            lo_r <= div_s ? lo_div_s : lo_mul_s;
`else
            hi_r <= hi_mul_s;
            lo_r <= lo_mul_s;
`endif
            cnt_r <= cnt_r + 6'd1;
            if (cnt_r == 6'(ITER_COUNT - 1)) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_ITER;
            end
          end else begin
            state_r <= ST_ITER;
          end
        end
        ST_FIX: begin
          hi_r    <= neg_dout_s[63:32];
          lo_r    <= neg_dout_s[31:0];
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          dz_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          dz_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: behavioural ALU, arithmetic reference
// model, directed cases plus randomized ops with random grant patterns.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, dz;
  logic [31:0] hi, lo;
  logic        alu_req, alu_gnt;
  logic [31:0] alu_a, alu_b, alu_q;
  logic [3:0]  alu_control;
  logic        alu_cf;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_q(alu_q), .alu_cf(alu_cf)
  );

  // Shared ALU: ADDU with carry-out, SUBU with cf meaning no borrow
  always_comb begin
    alu_q  = 32'd0;
    alu_cf = 1'b0;
    case (alu_control)
      4'b0110: {alu_cf, alu_q} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b1011: begin
        alu_q  = alu_a - alu_b;
        alu_cf = (alu_a >= alu_b);
      end
      default: begin
        alu_q  = 32'd0;
        alu_cf = 1'b0;
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l,
                                output logic d, output int lat);
    longint      sp, sq, sr;
    logic [63:0] up;
    h = m_hi; l = m_lo; d = 1'b0; lat = 35;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(sp);
        h = up[63:32]; l = up[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32]; l = up[31:0];
      end
      default: begin
        if (!DIV_EN) begin
          d = 1'b1; lat = 1;
        end else if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; d = 1'b1; lat = 2;
        end else if (o == 2'b10) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          up = 64'(sq); l = up[31:0];
          up = 64'(sr); h = up[31:0];
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  // gmode: 0 always grant, 1 alternate, 2 random; noisy adds stray start pulses
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int gmode, input bit noisy);
    logic [31:0] eh, el;
    logic        ed, seen;
    int          lat, denied, n;
    model(o, a, b, eh, el, ed, lat);
    denied = 0; seen = 1'b0;
    op = o; src_a = a; src_b = b; start = 1'b1;
    alu_gnt = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) src_a = $urandom;
      case (gmode)
        0: alu_gnt = 1'b1;
        1: alu_gnt = n[0];
        default: alu_gnt = 1'($urandom_range(0, 1));
      endcase
      if (alu_req && !alu_gnt) denied++;
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(n), 64'(lat + denied));
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    check("dz", 64'(dz), 64'(ed));
    check("busy_done", 64'(busy), 64'd1);
    m_hi = eh; m_lo = el;
    @(negedge clk);
    check("idle_busy_done", {62'd0, busy, done}, 64'd0);
    check("idle_alu", {alu_req, alu_control, alu_a, alu_b}, 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = 32'($urandom_range(0, 20));
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0; alu_gnt = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_status", {61'd0, busy, done, dz}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_alu", {alu_req, alu_control, alu_a, alu_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 0, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b01, 32'd3, 32'd5, 1, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 2, 1'b1);

    // Abort a MULTU during ITER step 10
    op = 2'b01; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; start = 1'b1; alu_gnt = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_status", {60'd0, busy, done, dz, alu_req}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_alu", {alu_control, alu_a, alu_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), rnd_val(), rnd_val(),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
